int_br_recovery_arbiter: RTL and testbench

INT_BR_RECOVERY_ARBITER -- requirements
Module: IntBrRecoveryArbiter

---
 rtl/int_br_recovery_arbiter.sv | 169 ++++++++++++++++
 tb/tb_int_br_recovery_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_br_recovery_arbiter.sv
// Integer-lane branch recovery arbiter: picks the oldest mispredicted branch
// and hands it to the recovery manager, buffering one older follow-up.
module int_br_recovery_arbiter #(
  parameter int ISSUE_WIDTH  = 2,
  parameter int AL_PTR_WIDTH = 6,
  parameter int PC_WIDTH     = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     stall,
  input  logic [ISSUE_WIDTH-1:0]                   brValid,
  input  logic [ISSUE_WIDTH-1:0]                   brMispred,
  input  logic [ISSUE_WIDTH-1:0][AL_PTR_WIDTH-1:0] brAlPtr,
  input  logic [ISSUE_WIDTH-1:0][PC_WIDTH-1:0]     brNextAddr,
  input  logic [AL_PTR_WIDTH-1:0]                  alHeadPtr,
  output logic                                     recoveryReq,
  output logic [AL_PTR_WIDTH-1:0]                  recoveryPtr,
  output logic [PC_WIDTH-1:0]                      recoveryAddr,
  input  logic                                     recoveryAck,
  input  logic                                     recoveryDone,
  output logic [15:0]                              mispredCount,
  output logic [1:0]                               dbgState
);

  // Handshake: recoveryReq is high for the whole REQ state and carries the
  // registered held slot; a transfer happens on the rising edge where
  // recoveryReq and recoveryAck are both high. Before that edge the held slot
  // may only be upgraded to an older branch, never to a younger one.

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    RECOVERING = 2'd2
  } stateT;

  stateT state, stateNext;

  logic [AL_PTR_WIDTH-1:0] heldPtr, heldPtrNext;
  logic [PC_WIDTH-1:0]     heldAddr, heldAddrNext;
  logic                    pendValid, pendValidNext;
  logic [AL_PTR_WIDTH-1:0] pendPtr, pendPtrNext;
  logic [PC_WIDTH-1:0]     pendAddr, pendAddrNext;
  logic [15:0]             countQ;
  logic [15:0]             mispredCountNext;
  logic                    countInc;

  logic [ISSUE_WIDTH-1:0][AL_PTR_WIDTH-1:0] laneAge;
  logic                    winValid;
  logic [AL_PTR_WIDTH-1:0] winPtr;
  logic [AL_PTR_WIDTH-1:0] winAge;
  logic [PC_WIDTH-1:0]     winAddr;
  logic [AL_PTR_WIDTH-1:0] heldAge;
  logic [AL_PTR_WIDTH-1:0] pendAge;
  logic                    winOlderThanHeld;
  logic                    winTakesPend;

  // Ages are distances from the head modulo the pointer range, so wrap is free.
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      laneAge[i] = brAlPtr[i] - alHeadPtr;
    end
  end

  assign heldAge = heldPtr - alHeadPtr;
  assign pendAge = pendPtr - alHeadPtr;

  // Strict less-than keeps the lowest lane on an age tie.
  always_comb begin
    winValid = 1'b0;
    winPtr   = '0;
    winAge   = '0;
    winAddr  = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (!stall && brValid[i] && brMispred[i] && (!winValid || (laneAge[i] < winAge))) begin
        winValid = 1'b1;
        winPtr   = brAlPtr[i];
        winAge   = laneAge[i];
        winAddr  = brNextAddr[i];
      end
    end
  end

  assign winOlderThanHeld = winValid && (winAge < heldAge);
  assign winTakesPend     = winOlderThanHeld && (!pendValid || (winAge < pendAge));

  always_comb begin
    stateNext     = state;
    heldPtrNext   = heldPtr;
    heldAddrNext  = heldAddr;
    pendValidNext = pendValid;
    pendPtrNext   = pendPtr;
    pendAddrNext  = pendAddr;
    countInc      = 1'b0;
    case (state)
      IDLE: begin
        if (winValid) begin
          heldPtrNext  = winPtr;
          heldAddrNext = winAddr;
          stateNext    = REQ;
        end
      end
      REQ: begin
        if (recoveryAck) begin
          // The held slot is what was acknowledged; an older arrival waits.
          countInc  = 1'b1;
          stateNext = RECOVERING;
          if (winTakesPend) begin
            pendValidNext = 1'b1;
            pendPtrNext   = winPtr;
            pendAddrNext  = winAddr;
          end
        end else if (winOlderThanHeld) begin
          heldPtrNext  = winPtr;
          heldAddrNext = winAddr;
        end
      end
      RECOVERING: begin
        if (recoveryDone) begin
          pendValidNext = 1'b0;
          if (winTakesPend) begin
            heldPtrNext  = winPtr;
            heldAddrNext = winAddr;
            stateNext    = REQ;
          end else if (pendValid) begin
            heldPtrNext  = pendPtr;
            heldAddrNext = pendAddr;
            stateNext    = REQ;
          end else begin
            stateNext = IDLE;
          end
        end else if (winTakesPend) begin
          pendValidNext = 1'b1;
          pendPtrNext   = winPtr;
          pendAddrNext  = winAddr;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign mispredCountNext = (countInc && (countQ != 16'hFFFF)) ? countQ + 16'd1 : countQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      heldPtr   <= '0;
      heldAddr  <= '0;
      pendValid <= 1'b0;
      pendPtr   <= '0;
      pendAddr  <= '0;
      countQ    <= '0;
    end else begin
      state     <= stateNext;
      heldPtr   <= heldPtrNext;
      heldAddr  <= heldAddrNext;
      pendValid <= pendValidNext;
      pendPtr   <= pendPtrNext;
      pendAddr  <= pendAddrNext;
      countQ    <= mispredCountNext;
    end
  end

  assign recoveryReq  = (state == REQ);
  assign recoveryPtr  = heldPtr;
  assign recoveryAddr = heldAddr;
  assign mispredCount = countQ;
  assign dbgState     = state;

endmodule

// File: tb/tb_int_br_recovery_arbiter.sv
// Directed-vector bench for int_br_recovery_arbiter with hand-computed expectations.
module tb_int_br_recovery_arbiter;
  localparam int IW = 2;
  localparam int AW = 6;
  localparam int PW = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   stall;
  logic [IW-1:0]          brValid;
  logic [IW-1:0]          brMispred;
  logic [IW-1:0][AW-1:0]  brAlPtr;
  logic [IW-1:0][PW-1:0]  brNextAddr;
  logic [AW-1:0]          alHeadPtr;
  logic                   recoveryReq;
  logic [AW-1:0]          recoveryPtr;
  logic [PW-1:0]          recoveryAddr;
  logic                   recoveryAck;
  logic                   recoveryDone;
  logic [15:0]            mispredCount;
  logic [1:0]             dbgState;

  int testsRun = 0;
  int testsFailed = 0;

  int_br_recovery_arbiter #(.ISSUE_WIDTH(IW), .AL_PTR_WIDTH(AW), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .brValid(brValid), .brMispred(brMispred),
    .brAlPtr(brAlPtr), .brNextAddr(brNextAddr), .alHeadPtr(alHeadPtr),
    .recoveryReq(recoveryReq), .recoveryPtr(recoveryPtr), .recoveryAddr(recoveryAddr),
    .recoveryAck(recoveryAck), .recoveryDone(recoveryDone),
    .mispredCount(mispredCount), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_lanes();
    stall = 1'b0; brValid = '0; brMispred = '0; brAlPtr = '0; brNextAddr = '0;
    recoveryAck = 1'b0; recoveryDone = 1'b0;
  endtask

  task automatic drive_lane(input int lane, input logic [AW-1:0] ptr, input logic [PW-1:0] addr);
    brValid[lane] = 1'b1; brMispred[lane] = 1'b1; brAlPtr[lane] = ptr; brNextAddr[lane] = addr;
  endtask

  // One clock: inputs set before this are sampled on the rising edge; outputs are read at the falling edge.
  task automatic cycle();
    @(negedge clk);
    clear_lanes();
  endtask

  task automatic apply_reset();
    clear_lanes(); alHeadPtr = '0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_lanes(); alHeadPtr = '0; rst = 1'b0;
    #2;
    testsRun++; if (recoveryReq !== 1'b0) begin testsFailed++; $display("FAIL reset_req: got %0b want 0", recoveryReq); end
    testsRun++; if (recoveryPtr !== 6'd0) begin testsFailed++; $display("FAIL reset_ptr: got %0d want 0", recoveryPtr); end
    testsRun++; if (recoveryAddr !== 32'd0) begin testsFailed++; $display("FAIL reset_addr: got %0h want 0", recoveryAddr); end
    testsRun++; if (mispredCount !== 16'd0) begin testsFailed++; $display("FAIL reset_count: got %0h want 0", mispredCount); end
    testsRun++; if (dbgState !== 2'd0) begin testsFailed++; $display("FAIL reset_state: got %0d want 0", dbgState); end
    @(negedge clk);
    rst = 1'b1;
    drive_lane(0, 6'd20, 32'h1234);
    cycle();
    testsRun++; if (recoveryReq !== 1'b1 || recoveryPtr !== 6'd20 || recoveryAddr !== 32'h1234) begin
      testsFailed++; $display("FAIL reset_first_accept: got req=%0b ptr=%0d addr=%0h want req=1 ptr=20 addr=1234", recoveryReq, recoveryPtr, recoveryAddr); end
  endtask

  task automatic test_oldest();
    apply_reset();
    drive_lane(0, 6'd5, 32'h100); drive_lane(1, 6'd3, 32'h200);
    cycle();
    testsRun++; if (recoveryReq !== 1'b1) begin testsFailed++; $display("FAIL oldest_req: got %0b want 1", recoveryReq); end
    testsRun++; if (recoveryPtr !== 6'd3) begin testsFailed++; $display("FAIL oldest_ptr: got %0d want 3", recoveryPtr); end
    testsRun++; if (recoveryAddr !== 32'h200) begin testsFailed++; $display("FAIL oldest_addr: got %0h want 200", recoveryAddr); end
    recoveryAck = 1'b1;
    cycle();
    testsRun++; if (dbgState !== 2'd2 || recoveryReq !== 1'b0) begin testsFailed++; $display("FAIL oldest_ack_state: got state=%0d req=%0b want state=2 req=0", dbgState, recoveryReq); end
    testsRun++; if (mispredCount !== 16'd1) begin testsFailed++; $display("FAIL oldest_ack_count: got %0d want 1", mispredCount); end
    recoveryAck = 1'b1;
    cycle();
    testsRun++; if (mispredCount !== 16'd1 || dbgState !== 2'd2) begin testsFailed++; $display("FAIL ack_ignored_recovering: got count=%0d state=%0d want count=1 state=2", mispredCount, dbgState); end
    recoveryDone = 1'b1;
    cycle();
    testsRun++; if (dbgState !== 2'd0) begin testsFailed++; $display("FAIL oldest_done_idle: got %0d want 0", dbgState); end
    recoveryAck = 1'b1; recoveryDone = 1'b1;
    cycle();
    testsRun++; if (dbgState !== 2'd0 || mispredCount !== 16'd1) begin testsFailed++; $display("FAIL idle_ignores_ack_done: got state=%0d count=%0d want state=0 count=1", dbgState, mispredCount); end
  endtask

  task automatic test_wraparound();
    apply_reset();
    alHeadPtr = 6'd60;
    drive_lane(0, 6'd2, 32'h300); drive_lane(1, 6'd62, 32'h400);
    cycle();
    testsRun++; if (recoveryPtr !== 6'd62 || recoveryAddr !== 32'h400) begin
      testsFailed++; $display("FAIL wrap_select: got ptr=%0d addr=%0h want ptr=62 addr=400", recoveryPtr, recoveryAddr); end
    apply_reset();
    drive_lane(0, 6'd9, 32'h500); drive_lane(1, 6'd9, 32'h600);
    cycle();
    testsRun++; if (recoveryPtr !== 6'd9 || recoveryAddr !== 32'h500) begin
      testsFailed++; $display("FAIL tie_low_lane: got ptr=%0d addr=%0h want ptr=9 addr=500", recoveryPtr, recoveryAddr); end
  endtask

  task automatic test_replace();
    apply_reset();
    drive_lane(0, 6'd10, 32'hA0);
    cycle();
    testsRun++; if (recoveryPtr !== 6'd10) begin testsFailed++; $display("FAIL replace_initial: got %0d want 10", recoveryPtr); end
    drive_lane(1, 6'd8, 32'h80);
    cycle();
    testsRun++; if (recoveryPtr !== 6'd8 || recoveryAddr !== 32'h80 || dbgState !== 2'd1) begin
      testsFailed++; $display("FAIL replace_older: got ptr=%0d addr=%0h state=%0d want ptr=8 addr=80 state=1", recoveryPtr, recoveryAddr, dbgState); end
    drive_lane(0, 6'd12, 32'hC0);
    cycle();
    testsRun++; if (recoveryPtr !== 6'd8 || recoveryAddr !== 32'h80) begin
      testsFailed++; $display("FAIL replace_younger_dropped: got ptr=%0d addr=%0h want ptr=8 addr=80", recoveryPtr, recoveryAddr); end
    drive_lane(1, 6'd8, 32'h88);
    cycle();
    testsRun++; if (recoveryAddr !== 32'h80) begin testsFailed++; $display("FAIL replace_equal_dropped: got %0h want 80", recoveryAddr); end
    recoveryDone = 1'b1;
    cycle();
    testsRun++; if (dbgState !== 2'd1 || recoveryReq !== 1'b1) begin
      testsFailed++; $display("FAIL req_ignores_done: got state=%0d req=%0b want state=1 req=1", dbgState, recoveryReq); end
  endtask

  task automatic test_ack_pending();
    apply_reset();
    drive_lane(0, 6'd10, 32'hA0);
    cycle();
    recoveryAck = 1'b1; drive_lane(1, 6'd7, 32'h70);
    cycle();
    testsRun++; if (dbgState !== 2'd2 || mispredCount !== 16'd1 || recoveryPtr !== 6'd10) begin
      testsFailed++; $display("FAIL ackpend_recovering: got state=%0d count=%0d ptr=%0d want state=2 count=1 ptr=10", dbgState, mispredCount, recoveryPtr); end
    drive_lane(0, 6'd9, 32'h90);
    cycle();
    drive_lane(0, 6'd12, 32'hC0);
    cycle();
    recoveryDone = 1'b1;
    cycle();
    testsRun++; if (dbgState !== 2'd1 || recoveryReq !== 1'b1 || recoveryPtr !== 6'd7 || recoveryAddr !== 32'h70) begin
      testsFailed++; $display("FAIL ackpend_promote: got state=%0d req=%0b ptr=%0d addr=%0h want state=1 req=1 ptr=7 addr=70", dbgState, recoveryReq, recoveryPtr, recoveryAddr); end
    recoveryAck = 1'b1;
    cycle();
    testsRun++; if (mispredCount !== 16'd2) begin testsFailed++; $display("FAIL ackpend_count2: got %0d want 2", mispredCount); end
    drive_lane(0, 6'd4, 32'h40);
    cycle();
    recoveryDone = 1'b1; drive_lane(1, 6'd3, 32'h30);
    cycle();
    testsRun++; if (dbgState !== 2'd1 || recoveryPtr !== 6'd3 || recoveryAddr !== 32'h30) begin
      testsFailed++; $display("FAIL done_cand_vs_pend: got state=%0d ptr=%0d addr=%0h want state=1 ptr=3 addr=30", dbgState, recoveryPtr, recoveryAddr); end
    recoveryAck = 1'b1;
    cycle();
    recoveryDone = 1'b1;
    cycle();
    testsRun++; if (dbgState !== 2'd0 || recoveryReq !== 1'b0 || mispredCount !== 16'd3) begin
      testsFailed++; $display("FAIL ackpend_final: got state=%0d req=%0b count=%0d want state=0 req=0 count=3", dbgState, recoveryReq, mispredCount); end
  endtask

  task automatic test_stall();
    apply_reset();
    stall = 1'b1; drive_lane(0, 6'd5, 32'h55);
    cycle();
    testsRun++; if (dbgState !== 2'd0 || recoveryReq !== 1'b0) begin
      testsFailed++; $display("FAIL stall_idle: got state=%0d req=%0b want state=0 req=0", dbgState, recoveryReq); end
    drive_lane(0, 6'd10, 32'hA0);
    cycle();
    stall = 1'b1; recoveryAck = 1'b1; drive_lane(1, 6'd2, 32'h22);
    cycle();
    testsRun++; if (dbgState !== 2'd2 || mispredCount !== 16'd1) begin
      testsFailed++; $display("FAIL stall_ack: got state=%0d count=%0d want state=2 count=1", dbgState, mispredCount); end
    recoveryDone = 1'b1;
    cycle();
    testsRun++; if (dbgState !== 2'd0) begin testsFailed++; $display("FAIL stall_no_pending: got state=%0d want 0", dbgState); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    drive_lane(0, 6'd10, 32'hA0);
    cycle();
    recoveryAck = 1'b1; drive_lane(1, 6'd7, 32'h70);
    cycle();
    #2;
    rst = 1'b0;
    #1;
    testsRun++; if (recoveryReq !== 1'b0 || recoveryPtr !== 6'd0 || recoveryAddr !== 32'd0) begin
      testsFailed++; $display("FAIL midflight_outputs: got req=%0b ptr=%0d addr=%0h want 0 0 0", recoveryReq, recoveryPtr, recoveryAddr); end
    testsRun++; if (mispredCount !== 16'd0 || dbgState !== 2'd0) begin
      testsFailed++; $display("FAIL midflight_state: got count=%0d state=%0d want 0 0", mispredCount, dbgState); end
    @(negedge clk);
    rst = 1'b1;
    cycle(); cycle(); cycle();
    testsRun++; if (recoveryReq !== 1'b0 || dbgState !== 2'd0) begin
      testsFailed++; $display("FAIL midflight_quiet: got req=%0b state=%0d want req=0 state=0", recoveryReq, dbgState); end
  endtask

  task automatic test_saturation();
    apply_reset();
    force dut.mispredCountNext = 16'hFFFE;
    cycle();
    release dut.mispredCountNext;
    testsRun++; if (mispredCount !== 16'hFFFE) begin testsFailed++; $display("FAIL sat_preload: got %0h want fffe", mispredCount); end
    for (int k = 0; k < 3; k++) begin
      drive_lane(0, 6'd10, 32'hA0);
      cycle();
      recoveryAck = 1'b1;
      cycle();
      testsRun++; if (mispredCount !== 16'hFFFF) begin testsFailed++; $display("FAIL sat_ack%0d: got %0h want ffff", k, mispredCount); end
      recoveryDone = 1'b1;
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_oldest();
    test_wraparound();
    test_replace();
    test_ack_pending();
    test_stall();
    test_reset_midflight();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
